// File: rtl/vga_write_arbiter.sv
// Framebuffer write-port arbiter: grants one drawing engine per burst and forwards its pixel writes one cycle later.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin priority; otherwise fixed priority (index 0 highest).
module vga_write_arbiter #(
    parameter int NREQ        = 4,
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int MAX_BURST   = 4096
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             wr_en,
    input  logic [NREQ*nX-1:0]          x_in,
    input  logic [NREQ*nY-1:0]          y_in,
    input  logic [NREQ*COLOR_DEPTH-1:0] color_in,
    output logic [NREQ-1:0]             grant,
    output logic [nX-1:0]               vga_x,
    output logic [nY-1:0]               vga_y,
    output logic [COLOR_DEPTH-1:0]      vga_color,
    output logic                        vga_write,
    output logic                        busy,
    output logic                        drop_err
);

    localparam int OW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWNED   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [OW-1:0]            r_owner;
    logic [OW-1:0]            w_owner_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [NREQ-1:0]          r_mask;
    logic [NREQ-1:0]          w_mask_nxt;
    logic [NREQ-1:0]          r_grant;
    logic [NREQ-1:0]          w_grant_nxt;
    logic [nX-1:0]            r_vga_x;
    logic [nY-1:0]            r_vga_y;
    logic [COLOR_DEPTH-1:0]   r_vga_color;
    logic                     r_vga_write;
    logic                     r_drop_err;

    logic [NREQ-1:0]          w_cand;
    logic [NREQ-1:0]          w_owner_oh;
    logic [NREQ-1:0]          w_winner_oh;
    logic [OW-1:0]            w_winner;
    logic                     w_found;
    logic                     w_others;
    logic                     w_force;
    logic                     w_fwd;
    logic                     w_drop;

`ifdef ARB_ROUND_ROBIN_EN
    logic [OW-1:0]            r_last;
`endif

    // Winner search; the mask is dropped when it would hide every pending request.
    always_comb begin
        int idx;
        idx      = 0;
        w_cand   = req & ~r_mask;
        if (w_cand == '0) begin
            w_cand = req;
        end
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            idx = (int'(r_last) + 1 + k) % NREQ;
`else
            idx = k;
`endif
            if (!w_found && w_cand[idx]) begin
                w_found  = 1'b1;
                w_winner = OW'(idx);
            end
        end
    end

    always_comb begin
        w_owner_oh           = '0;
        w_owner_oh[r_owner]  = 1'b1;
        w_winner_oh          = '0;
        w_winner_oh[w_winner] = 1'b1;
        w_others = |(req & ~w_owner_oh);
        w_force  = (MAX_BURST != 0) && (r_cnt == CNT_LAST) && w_others;
        w_fwd    = (r_state == S_OWNED) && wr_en[r_owner];
        w_drop   = |(wr_en & ~r_grant);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (w_found) begin
                    w_state_nxt = S_OWNED;
                    w_owner_nxt = w_winner;
                    w_grant_nxt = w_winner_oh;
                    w_cnt_nxt   = '0;
                    w_mask_nxt  = '0;
                end
            end
            S_OWNED: begin
                w_grant_nxt = w_owner_oh;
                if (!req[r_owner]) begin
                    w_state_nxt = S_RELEASE;
                    w_grant_nxt = '0;
                end else if (w_force) begin
                    // Preempted owner is masked so it loses the next arbitration.
                    w_state_nxt         = S_RELEASE;
                    w_grant_nxt         = '0;
                    w_mask_nxt[r_owner] = 1'b1;
                end else if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_grant     <= '0;
            r_vga_write <= 1'b0;
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_color <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mask      <= w_mask_nxt;
            r_grant     <= w_grant_nxt;
            r_vga_write <= w_fwd;
            if (w_fwd) begin
                r_vga_x     <= x_in[r_owner*nX +: nX];
                r_vga_y     <= y_in[r_owner*nY +: nY];
                r_vga_color <= color_in[r_owner*COLOR_DEPTH +: COLOR_DEPTH];
            end
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= OW'(NREQ - 1);
        end else if (r_state == S_IDLE && w_found) begin
            r_last <= w_winner;
        end
    end
`endif

    assign grant     = r_grant;
    assign vga_x     = r_vga_x;
    assign vga_y     = r_vga_y;
    assign vga_color = r_vga_color;
    assign vga_write = r_vga_write;
    assign busy      = (r_state != S_IDLE);
    assign drop_err  = r_drop_err;

endmodule
